// File: rtl/stim_pacer.sv
// stim_pacer: streams preloaded samples at a programmable interval, one-shot or looping,
// while counting filter responses and measuring first-sample-to-first-response latency.
module stim_pacer #(
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = 11,
    parameter int IVL_W     = 8,
    parameter int DRAIN_CYC = 100,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    input  logic [IVL_W-1:0]  interval,
    input  logic [ADDR_W:0]   length,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              resp_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  resp_cnt,
    output logic [CNT_W-1:0]  latency,
    output logic              latency_valid
);
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mode_q, mode_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [IVL_W-1:0]  period_q, period_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  sample_q, sample_d;
    logic [CNT_W-1:0]  resp_q, resp_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  latency_q, latency_d;
    logic              lat_valid_q, lat_valid_d;
    logic              emit;

    assign busy          = state_q != IDLE;
    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign done          = done_q;
    assign sample_cnt    = sample_q;
    assign resp_cnt      = resp_q;
    assign latency       = latency_q;
    assign latency_valid = lat_valid_q;

    // Memory is only writable while idle so a running pass never sees torn data.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && {1'b0, wr_addr} < DEPTH_L)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ivl_d       = ivl_q;
        len_d       = len_q;
        period_d    = period_q;
        rd_idx_d    = rd_idx_q;
        drain_d     = drain_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;
        sample_d    = sample_q;
        resp_d      = (busy && resp_valid) ? resp_q + CNT_W'(1) : resp_q;
        lat_cnt_d   = lat_cnt_q;
        armed_d     = armed_q;
        latency_d   = latency_q;
        lat_valid_d = lat_valid_q;
        emit        = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d     = RUN;
                    mode_d      = loop_mode;
                    ivl_d       = (interval == '0) ? IVL_W'(1) : interval;
                    len_d       = (length > DEPTH_L) ? DEPTH_L : length;
                    period_d    = '0;
                    rd_idx_d    = '0;
                    sample_d    = '0;
                    resp_d      = '0;
                    lat_cnt_d   = '0;
                    armed_d     = 1'b0;
                    latency_d   = '0;
                    lat_valid_d = 1'b0;
                end
                RUN: begin
                    if (len_q == '0) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else if (period_q == ivl_q - IVL_W'(1)) begin
                        emit     = 1'b1;
                        period_d = '0;
                        data_d   = mem[rd_idx_q];
                        valid_d  = 1'b1;
                        sample_d = sample_q + CNT_W'(1);
                        if ({1'b0, rd_idx_q} == len_q - (ADDR_W + 1)'(1)) begin
                            rd_idx_d = '0;
                            state_d  = mode_q ? RUN : DRAIN;
                            drain_d  = '0;
                        end else begin
                            rd_idx_d = rd_idx_q + ADDR_W'(1);
                        end
                    end else begin
                        period_d = period_q + IVL_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == DRN_W'(DRAIN_CYC - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + DRN_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // Latency arms on the first emit; a response on that same edge reads as zero.
            if (busy && !lat_valid_q && (armed_q || emit)) begin
                if (resp_valid) begin
                    latency_d   = armed_q ? lat_cnt_q : '0;
                    lat_valid_d = 1'b1;
                end else begin
                    armed_d   = 1'b1;
                    lat_cnt_d = !armed_q ? CNT_W'(1) : (&lat_cnt_q ? lat_cnt_q : lat_cnt_q + CNT_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            ivl_q       <= '0;
            len_q       <= '0;
            period_q    <= '0;
            rd_idx_q    <= '0;
            drain_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            sample_q    <= '0;
            resp_q      <= '0;
            lat_cnt_q   <= '0;
            armed_q     <= 1'b0;
            latency_q   <= '0;
            lat_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ivl_q       <= ivl_d;
            len_q       <= len_d;
            period_q    <= period_d;
            rd_idx_q    <= rd_idx_d;
            drain_q     <= drain_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            sample_q    <= sample_d;
            resp_q      <= resp_d;
            lat_cnt_q   <= lat_cnt_d;
            armed_q     <= armed_d;
            latency_q   <= latency_d;
            lat_valid_q <= lat_valid_d;
        end
    end
endmodule

// File: tb/tb_stim_pacer.sv
// tb_stim_pacer: randomized and directed runs of stim_pacer checked against an arithmetic
// model of emit times, drain end, response counts and latency.
module tb_stim_pacer;
    localparam int DATA_W    = 24;
    localparam int DEPTH     = 20;
    localparam int ADDR_W    = 5;
    localparam int IVL_W     = 8;
    localparam int DRAIN_CYC = 100;
    localparam int CNT_W     = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_mode = 1'b0;
    logic [IVL_W-1:0]  interval = '0;
    logic [ADDR_W:0]   length = '0;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              resp_valid = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  resp_cnt;
    logic [CNT_W-1:0]  latency;
    logic              latency_valid;

    logic [DATA_W-1:0] mmem [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    stim_pacer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IVL_W(IVL_W),
        .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_mode(loop_mode), .interval(interval), .length(length),
        .data_out(data_out), .valid_out(valid_out), .resp_valid(resp_valid), .busy(busy),
        .done(done), .sample_cnt(sample_cnt), .resp_cnt(resp_cnt), .latency(latency),
        .latency_valid(latency_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = DATA_W'(data);
        step();
        wr_en = 1'b0;
        if (addr < DEPTH) mmem[addr] = DATA_W'(data);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_scnt"}, sample_cnt, 0);
        chk({tag, "_rcnt"}, resp_cnt, 0);
        chk({tag, "_lat"}, latency, 0);
        chk({tag, "_latv"}, latency_valid, 0);
    endtask

    // Edge x (counted from the start edge) carries an emit when it is a whole number of
    // intervals past start and still within the pass count.
    function automatic bit is_emit(input int x, input int ivl, input int len, input bit oneshot);
        return len > 0 && x >= ivl && x % ivl == 0 && (!oneshot || x / ivl <= len);
    endfunction

    task automatic run(input int ivl_in, input int len_in, input bit lp, input int stop_at,
                       input int rdly, input bit wr_run);
        int ivl, len, end_t, n_emit, nresp, lat_e;
        bit oneshot, stopped, lat_seen, fin;
        ivl = (ivl_in == 0) ? 1 : ivl_in;
        len = (len_in > DEPTH) ? DEPTH : len_in;
        oneshot = !lp || len == 0;
        end_t = (len == 0) ? DRAIN_CYC + 1 : len * ivl + DRAIN_CYC;
        n_emit = 0; nresp = 0; lat_e = 0; stopped = 0; lat_seen = 0; fin = 0;
        start = 1'b1;
        interval = IVL_W'(ivl_in);
        length = (ADDR_W + 1)'(len_in);
        loop_mode = lp;
        step();
        chk("busy_start", busy, 1);
        interval = IVL_W'($urandom);
        length = (ADDR_W + 1)'($urandom);
        loop_mode = 1'($urandom);
        for (int t = 1; t <= 4000; t++) begin
            bit st, e;
            st = stopped;
            resp_valid = !st && rdly >= 0 && t > rdly && is_emit(t - rdly, ivl, len, oneshot);
            stop = st;
            start = 1'($urandom_range(0, 1));
            wr_en = wr_run;
            wr_addr = '0;
            wr_data = DATA_W'($urandom);
            step();
            if (st) begin
                chk("stop_busy", busy, 0);
                chk("stop_valid", valid_out, 0);
                chk("stop_done", done, 0);
                fin = 1;
                break;
            end
            if (resp_valid) begin
                nresp++;
                if (!lat_seen) begin
                    lat_seen = 1;
                    lat_e = t - ivl;
                end
            end
            e = is_emit(t, ivl, len, oneshot);
            chk("valid", valid_out, e);
            if (e) begin
                n_emit++;
                chk("data", data_out, mmem[(t / ivl - 1) % len]);
                chk("sample_run", sample_cnt, n_emit);
                if (stop_at > 0 && n_emit == stop_at) stopped = 1;
            end
            chk("busy", busy, !(oneshot && t >= end_t));
            chk("done", done, oneshot && t == end_t);
            if (oneshot && t == end_t) begin
                fin = 1;
                break;
            end
        end
        start = 1'b0; stop = 1'b0; resp_valid = 1'b0; wr_en = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("sample_cnt", sample_cnt, n_emit);
        chk("resp_cnt", resp_cnt, nresp);
        chk("latency", latency, lat_e);
        chk("latency_valid", latency_valid, lat_seen);
        step();
        chk("idle_done", done, 0);
    endtask

    initial begin
        int iv, ln, lp, sa, rd;
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset");
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom);

        for (int i = 0; i < 5; i++) wr(i, i + 1);
        run(10, 5, 0, 0, -1, 0);
        wr(0, 24'hA0A0A0); wr(1, 24'hB1B1B1); wr(2, 24'hC2C2C2);
        run(1, 3, 1, 7, -1, 0);
        run(10, 4, 0, 0, 6, 0);
        run(0, 3, 0, 0, 0, 0);
        run(5, 0, 0, 0, 2, 0);
        run(3, 0, 1, 0, -1, 0);
        run(1, 3, 1, 8, 1, 1);
        wr(DEPTH, 24'h123456);
        run(1, 31, 0, 0, 2, 0);

        start = 1'b1; stop = 1'b1; interval = 8'd2; length = 6'd3;
        step();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        step();
        chk("startstop_valid", valid_out, 0);
        chk("startstop_busy2", busy, 0);

        start = 1'b1; interval = 8'd2; length = 6'd10; loop_mode = 1'b0;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        run(4, 6, 0, 0, 3, 0);

        for (int r = 0; r < 30; r++) begin
            iv = $urandom_range(0, 6);
            ln = $urandom_range(0, 24);
            lp = $urandom_range(0, 1);
            rd = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 12);
            sa = (lp != 0 && ln > 0) ? $urandom_range(1, 2 * ln + 2) : 0;
            repeat (3) wr($urandom_range(0, DEPTH + 3), $urandom);
            run(iv, ln, lp[0], sa, rd, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
